// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO that feeds a UART transmitter one byte at a time,
// issuing each byte only after the previous byte's tx_complete.
//
// state  | meaning
// IDLE   | no byte in flight; pops the FIFO head into tx_byte when data is present
// STROBE | byte loaded; the registered tx_en goes low for one cycle on the next edge
// WAIT   | transmitter owns the byte; hold tx_byte until tx_complete
module uart_tx_buffer #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  sourceClk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    input  logic                  ovf_clr,
    output logic                  tx_en,
    output logic [7:0]            tx_byte,
    input  logic                  tx_complete,
    output logic                  busy
);
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        WAIT
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [7:0]            mem [DEPTH];
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic                  push;
    logic                  pop;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    assign push  = wr_en && !full;
    assign busy  = (state != IDLE);

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = STROBE;
                end
            end
            STROBE:  state_next = WAIT;
            WAIT:    if (tx_complete) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // tx_en is registered from the state, so tx_byte is already stable for a
    // full cycle when the strobe reaches the transmitter.
    always_ff @(posedge sourceClk) begin
        if (reset) begin
            state    <= IDLE;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            tx_en    <= 1'b1;
            tx_byte  <= 8'h00;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            tx_en <= (state != STROBE);
            if (pop) begin
                tx_byte <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge sourceClk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer: 8N1 transmitter/receiver models, a FIFO vector
// table and directed sequences for latency, ordering, overflow and reset.
module tb_uart_tx_buffer;
    localparam int BIT = 4;
    localparam int NV  = 22;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       ovf_clr;
    logic       tx_en;
    logic [7:0] tx_byte;
    logic       tx_complete;
    logic       busy;

    logic       line;
    logic       stall;
    int         spur_req;
    int         spur_done;
    int         checks;
    int         errors;
    int         cyc;
    logic [7:0] rxq[$];
    int         strobes[$];
    int         cpls[$];

    typedef struct {
        logic       wr_en;
        logic [7:0] wr_data;
        logic       ovf_clr;
        logic [4:0] count;
        logic       full;
        logic       empty;
        logic       overflow;
        logic       busy;
        logic [7:0] tx_byte;
    } vec_t;

    vec_t vecs[NV];

    uart_tx_buffer #(.DEPTH(16), .ADDR_WIDTH(4)) dut (
        .sourceClk  (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .tx_en      (tx_en),
        .tx_byte    (tx_byte),
        .tx_complete(tx_complete),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic we, input logic [7:0] d, input logic clr,
                           input logic [4:0] cnt, input logic f, input logic e, input logic o,
                           input logic b, input logic [7:0] tb);
        vecs[i].wr_en    = we;
        vecs[i].wr_data  = d;
        vecs[i].ovf_clr  = clr;
        vecs[i].count    = cnt;
        vecs[i].full     = f;
        vecs[i].empty    = e;
        vecs[i].overflow = o;
        vecs[i].busy     = b;
        vecs[i].tx_byte  = tb;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Returns at the posedge where the DUT samples tx_complete high.
    task automatic wait_cpl(input string name);
        int n;
        n = 0;
        @(posedge clk);
        while (tx_complete !== 1'b1 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check(name, 32'(n < 500), 1);
    endtask

    task automatic wait_rx(input int num, input string name);
        int n;
        n = 0;
        while (rxq.size() < num && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(rxq.size() >= num), 1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy !== 1'b0 || empty !== 1'b1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n < 3000), 1);
    endtask

    // Cycle counter; records the cycle in which tx_complete was high.
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            if (tx_complete === 1'b1) cpls.push_back(cyc);
            cyc++;
        end
    end

    // Strobe monitor: tx_en must never be low two cycles running.
    initial begin
        bit prev_low;
        prev_low = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_en === 1'b0) begin
                strobes.push_back(cyc);
                check("tx_en_single_cycle", 32'(prev_low), 0);
            end
            prev_low = (tx_en === 1'b0);
        end
    end

    // Transmitter model: latch the byte on the strobe, serialize 8N1, pulse tx_complete.
    initial begin
        logic [7:0] b;
        line        = 1'b1;
        tx_complete = 1'b0;
        forever begin
            @(negedge clk);
            if (spur_req != spur_done) begin
                tx_complete = 1'b1;
                @(negedge clk);
                tx_complete = 1'b0;
                spur_done++;
            end else if (tx_en === 1'b0) begin
                b = tx_byte;
                while (stall && !reset) @(negedge clk);
                if (!reset) begin
                    line = 1'b0;
                    repeat (BIT) @(negedge clk);
                    for (int i = 0; i < 8; i++) begin
                        line = b[i];
                        repeat (BIT) @(negedge clk);
                    end
                    line = 1'b1;
                    repeat (BIT) @(negedge clk);
                    tx_complete = 1'b1;
                    @(negedge clk);
                    tx_complete = 1'b0;
                end
            end
        end
    end

    // Serial receiver: samples each bit near its middle.
    initial begin
        logic [7:0] r;
        forever begin
            @(posedge clk);
            if (line === 1'b0) begin
                repeat (2) @(posedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(posedge clk);
                    r[i] = line;
                end
                repeat (BIT) @(posedge clk);
                check("rx_stop_bit", 32'(line), 1);
                rxq.push_back(r);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached with %0d errors", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int         p;
        int         peak;
        int         n0;
        logic [7:0] hello[5];
        logic [7:0] exp_q[$];

        checks    = 0;
        errors    = 0;
        spur_req  = 0;
        spur_done = 0;
        stall     = 1'b0;
        reset     = 1'b1;
        wr_en     = 1'b0;
        wr_data   = 8'h00;
        ovf_clr   = 1'b0;
        hello     = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};

        for (int i = 0; i <= 16; i++) begin
            set_vec(i, 1'b1, 8'(8'h30 + i), 1'b0, 5'((i == 0) ? 1 : i), (i == 16), 1'b0, 1'b0,
                    (i != 0), (i == 0) ? 8'h00 : 8'h30);
        end
        set_vec(17, 1'b1, 8'h41, 1'b0, 5'd16, 1'b1, 1'b0, 1'b1, 1'b1, 8'h30);
        set_vec(18, 1'b0, 8'h00, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0, 1'b1, 8'h30);
        set_vec(19, 1'b1, 8'h42, 1'b1, 5'd16, 1'b1, 1'b0, 1'b1, 1'b1, 8'h30);
        set_vec(20, 1'b0, 8'h00, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0, 1'b1, 8'h30);
        set_vec(21, 1'b0, 8'h00, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0, 1'b1, 8'h30);

        // Reset and idle
        do_reset();
        repeat (10) @(negedge clk);
        check("rst_tx_en", 32'(tx_en), 1);
        check("rst_tx_byte", 32'(tx_byte), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_count", 32'(count), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overflow", 32'(overflow), 0);

        // Single byte: strobe two cycles after the push edge
        strobes.delete();
        rxq.delete();
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        p       = cyc;
        @(negedge clk);
        wr_en = 1'b0;
        check("single_count", 32'(count), 1);
        check("single_empty", 32'(empty), 0);
        @(negedge clk);
        check("single_byte_before_strobe", 32'(tx_byte), 32'hA5);
        check("single_tx_en_pre", 32'(tx_en), 1);
        @(negedge clk);
        check("single_tx_en_low", 32'(tx_en), 0);
        @(negedge clk);
        check("single_tx_en_post", 32'(tx_en), 1);
        check("single_busy", 32'(busy), 1);
        wait_cpl("single_cpl_timeout");
        @(negedge clk);
        check("single_busy_drop", 32'(busy), 0);
        wait_rx(1, "single_rx_timeout");
        if (rxq.size() >= 1) check("single_rx_byte", 32'(rxq[0]), 32'hA5);
        if (strobes.size() >= 1) check("single_strobe_latency", strobes[0] - p, 3);
        check("single_strobe_count", strobes.size(), 1);

        // Burst "Hello"
        repeat (3) @(negedge clk);
        strobes.delete();
        cpls.delete();
        rxq.delete();
        peak = 0;
        p    = cyc;
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            wr_data = hello[i];
            @(negedge clk);
            if (int'(count) > peak) peak = int'(count);
        end
        wr_en = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (int'(count) > peak) peak = int'(count);
        end
        check("hello_count_peak", peak, 4);
        wait_rx(5, "hello_rx_timeout");
        for (int i = 0; i < 5; i++) begin
            if (rxq.size() > i) check($sformatf("hello_rx%0d", i), 32'(rxq[i]), 32'(hello[i]));
        end
        wait_idle("hello_idle_timeout");
        check("hello_strobe_count", strobes.size(), 5);
        if (strobes.size() >= 5 && cpls.size() >= 4) begin
            check("hello_first_latency", strobes[0] - p, 3);
            for (int i = 1; i < 5; i++) begin
                check($sformatf("hello_gap%0d", i), strobes[i] - cpls[i-1], 3);
            end
        end

        // FIFO fill/overflow table with the transmitter stalled
        stall = 1'b1;
        do_reset();
        for (int i = 0; i < NV; i++) begin
            wr_en   = vecs[i].wr_en;
            wr_data = vecs[i].wr_data;
            ovf_clr = vecs[i].ovf_clr;
            @(negedge clk);
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].count));
            check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].full));
            check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].empty));
            check($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].overflow));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            check($sformatf("vec%0d_tx_byte", i), 32'(tx_byte), 32'(vecs[i].tx_byte));
        end
        wr_en   = 1'b0;
        ovf_clr = 1'b0;

        // Push into a full FIFO in the pop cycle, then keep pushing across the wrap
        rxq.delete();
        stall = 1'b0;
        wait_cpl("wrap_cpl_timeout");
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = 8'hE0;
        @(negedge clk);
        check("wrap_pop_cycle_count", 32'(count), 15);
        check("wrap_pop_cycle_overflow", 32'(overflow), 1);
        check("wrap_pop_cycle_full", 32'(full), 0);
        wr_data = 8'hE1;
        @(negedge clk);
        check("wrap_refill_count", 32'(count), 16);
        for (int j = 2; j < 20; j++) begin
            wr_data = 8'(8'hE0 + j);
            @(negedge clk);
        end
        wr_en = 1'b0;
        check("wrap_hold_count", 32'(count), 16);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("wrap_ovf_clr", 32'(overflow), 0);
        exp_q.delete();
        for (int i = 0; i <= 16; i++) exp_q.push_back(8'(8'h30 + i));
        exp_q.push_back(8'hE1);
        wait_rx(18, "wrap_rx_timeout");
        check("wrap_rx_len", rxq.size(), 18);
        for (int i = 0; i < 18; i++) begin
            if (rxq.size() > i) check($sformatf("wrap_rx%0d", i), 32'(rxq[i]), 32'(exp_q[i]));
        end
        wait_idle("wrap_idle_timeout");

        // Reset while in WAIT with 3 bytes queued
        stall = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h11 + i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        check("midwait_count", 32'(count), 3);
        check("midwait_busy", 32'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midwait_rst_busy", 32'(busy), 0);
        check("midwait_rst_count", 32'(count), 0);
        check("midwait_rst_empty", 32'(empty), 1);
        check("midwait_rst_tx_en", 32'(tx_en), 1);
        stall = 1'b0;
        n0    = strobes.size();
        spur_req++;
        repeat (10) @(negedge clk);
        check("spurious_cpl_no_strobe", strobes.size(), n0);
        check("spurious_cpl_busy", 32'(busy), 0);
        check("spurious_cpl_tx_en", 32'(tx_en), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
